mux_nx1_reg: RTL

MUX_NX1_REG -- requirements
Module: mux_nx1_reg

---
 rtl/mux_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/mux_nx1_reg.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared types and defaults for the registered N:1 multiplexer.
//   mode_t      : select policy (fixed index or round-robin)
//   buf_state_t : occupancy of the two-entry output buffer
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned NUM_INPUTS_DEF = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority search.
//   req       : request vector, one bit per channel
//   ptr       : channel with highest priority this cycle
//   gnt_idx   : first requesting channel at or after ptr (wrapping)
//   gnt_valid : at least one channel is requesting
module rr_arbiter #(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [SEL_WIDTH-1:0]  ptr,
  output logic [SEL_WIDTH-1:0]  gnt_idx,
  output logic                  gnt_valid
);

  int unsigned idx;

  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      idx = (32'(ptr) + k) % NUM_INPUTS;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SEL_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_nx1_reg.sv
// Registered N:1 multiplexer with fixed or round-robin channel selection
// feeding a two-entry output buffer.
//   clk, reset          : clock (rising edge), asynchronous active-high reset
//   data_in, valid_in   : per-channel words and valids
//   ready_out           : per-channel accept (only the granted channel)
//   mode_in, sel_in     : select policy and fixed-mode channel index
//   mux_out, sel_out    : head word of the buffer and its source channel
//   valid_out, ready_in : downstream handshake
module mux_nx1_reg
  import mux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned NUM_INPUTS = NUM_INPUTS_DEF,
  parameter int unsigned SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] data_in,
  input  logic [NUM_INPUTS-1:0]                valid_in,
  output logic [NUM_INPUTS-1:0]                ready_out,
  input  logic                                 mode_in,
  input  logic [SEL_WIDTH-1:0]                 sel_in,
  output logic [DATA_WIDTH-1:0]                mux_out,
  output logic                                 valid_out,
  input  logic                                 ready_in,
  output logic [SEL_WIDTH-1:0]                 sel_out
);

  buf_state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0]     head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic [SEL_WIDTH-1:0]      head_sel_q, head_sel_d, tail_sel_q, tail_sel_d;
  logic [SEL_WIDTH-1:0]      rr_ptr_q, rr_ptr_d;
  logic [SEL_WIDTH-1:0]      rr_idx, gnt_idx;
  logic                      rr_valid, gnt_valid;
  logic                      push, pop;
  logic [DATA_WIDTH-1:0]     push_data;

  rr_arbiter #(
    .NUM_INPUTS (NUM_INPUTS),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_rr_arbiter (
    .req       (valid_in),
    .ptr       (rr_ptr_q),
    .gnt_idx   (rr_idx),
    .gnt_valid (rr_valid)
  );

  // Fixed mode grants sel_in even if that channel is idle; out-of-range
  // indices grant nothing.
  always_comb begin
    if (mode_t'(mode_in) == MODE_RR) begin
      gnt_idx   = rr_idx;
      gnt_valid = rr_valid;
    end else begin
      gnt_idx   = sel_in;
      gnt_valid = (32'(sel_in) < NUM_INPUTS);
    end
  end

  // ready_out never looks at ready_in, so a FULL buffer blocks input even
  // when a pop is happening this cycle.
  always_comb begin
    ready_out = '0;
    if (gnt_valid && (state_q != FULL)) begin
      ready_out[gnt_idx] = 1'b1;
    end
  end

  assign push      = |(ready_out & valid_in);
  assign push_data = data_in[gnt_idx];
  assign valid_out = (state_q != EMPTY);
  assign pop       = valid_out && ready_in;

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_sel_d  = head_sel_q;
    tail_data_d = tail_data_q;
    tail_sel_d  = tail_sel_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_data_d = push_data;
          head_sel_d  = gnt_idx;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_data_d = push_data;
          head_sel_d  = gnt_idx;
        end else if (push) begin
          tail_data_d = push_data;
          tail_sel_d  = gnt_idx;
          state_d     = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_data_d = tail_data_q;
          head_sel_d  = tail_sel_q;
          state_d     = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (push && (mode_t'(mode_in) == MODE_RR)) begin
      rr_ptr_d = (32'(gnt_idx) == NUM_INPUTS - 1) ? '0 : gnt_idx + SEL_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      head_data_q <= '0;
      head_sel_q  <= '0;
      tail_data_q <= '0;
      tail_sel_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_sel_q  <= head_sel_d;
      tail_data_q <= tail_data_d;
      tail_sel_q  <= tail_sel_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign mux_out = head_data_q;
  assign sel_out = head_sel_q;

endmodule
